// File: rtl/brat_ckpt_if.sv
// Rename/retire/mispredict bus between the front end and the branch RAT
// checkpoint controller.
//   master : drives alloc_req/alloc_robid, ret_branch_val/ret_robid,
//            mispredict_val/mispredict_robid; observes grant, stall, restore
//            and status signals.
//   slave  : the checkpoint controller itself.
interface brat_ckpt_if #(
   parameter int unsigned ISSUE_WIDTH_MAX     = 2,
   parameter int unsigned ROB_MAX_RETIRE      = 2,
   parameter int unsigned ROB_SIZE_CLOG       = 6,
   parameter int unsigned BRATCR_NUM_ETY_CLOG = 3
);
   logic [ISSUE_WIDTH_MAX-1:0]                          alloc_req;
   logic [ISSUE_WIDTH_MAX-1:0][ROB_SIZE_CLOG-1:0]       alloc_robid;
   logic                                                alloc_gnt;
   logic [ISSUE_WIDTH_MAX-1:0][BRATCR_NUM_ETY_CLOG-1:0] alloc_idx;
   logic                                                rename_stall;
   logic [ROB_MAX_RETIRE-1:0]                           ret_branch_val;
   logic [ROB_MAX_RETIRE-1:0][ROB_SIZE_CLOG-1:0]        ret_robid;
   logic                                                mispredict_val;
   logic [ROB_SIZE_CLOG-1:0]                            mispredict_robid;
   logic                                                mispredict_rdy;
   logic                                                restore_en;
   logic [BRATCR_NUM_ETY_CLOG-1:0]                      restore_idx;
   logic                                                bratcr_full;
   logic                                                ckpt_err;

   modport master (
      output alloc_req, alloc_robid, ret_branch_val, ret_robid,
             mispredict_val, mispredict_robid,
      input  alloc_gnt, alloc_idx, rename_stall, mispredict_rdy,
             restore_en, restore_idx, bratcr_full, ckpt_err
   );

   modport slave (
      input  alloc_req, alloc_robid, ret_branch_val, ret_robid,
             mispredict_val, mispredict_robid,
      output alloc_gnt, alloc_idx, rename_stall, mispredict_rdy,
             restore_en, restore_idx, bratcr_full, ckpt_err
   );
endinterface

// File: rtl/brat_ckpt_ctrl.sv
// Branch RAT checkpoint allocation/recovery controller.
// Checkpoint entries form a circular queue: up to ISSUE_WIDTH_MAX entries are
// allocated per cycle at rename, freed in order at retire, and CAM-searched on
// a mispredict, which launches a RESTORE/RESUME sequence stalling rename.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : brat_ckpt_if slave (alloc, retire, mispredict, restore, status)
module brat_ckpt_ctrl #(
   parameter int unsigned ISSUE_WIDTH_MAX     = 2,
   parameter int unsigned ROB_MAX_RETIRE      = 2,
   parameter int unsigned ROB_SIZE_CLOG       = 6,
   parameter int unsigned BRATCR_NUM_ETY      = 8,
   parameter int unsigned BRATCR_NUM_ETY_CLOG = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   brat_ckpt_if.slave  bus
);
   localparam int unsigned IW   = ISSUE_WIDTH_MAX;
   localparam int unsigned RW   = ROB_MAX_RETIRE;
   localparam int unsigned ROBW = ROB_SIZE_CLOG;
   localparam int unsigned N    = BRATCR_NUM_ETY;
   localparam int unsigned IDXW = BRATCR_NUM_ETY_CLOG;
   localparam int unsigned CNTW = BRATCR_NUM_ETY_CLOG + 1;

   typedef enum logic [1:0] {S_IDLE, S_RESTORE, S_RESUME} state_e;

   state_e                   state_q, state_d;
   logic [IDXW-1:0]          head_q, head_d;
   logic [IDXW-1:0]          tail_q, tail_d;
   logic [CNTW-1:0]          count_q, count_d;
   logic [N-1:0]             valid_q, valid_d;
   logic [N-1:0][ROBW-1:0]   robid_q, robid_d;
   logic                     restore_en_q, restore_en_d;
   logic [IDXW-1:0]          restore_idx_q, restore_idx_d;
   logic                     ckpt_err_q, ckpt_err_d;

   logic                     is_idle_c;
   logic [CNTW-1:0]          need_c;
   logic                     gnt_c;
   logic [IW-1:0][IDXW-1:0]  idx_c;
   logic [IDXW-1:0]          hp_c;
   logic [CNTW-1:0]          freed_c;
   logic                     hit_c;
   logic [IDXW-1:0]          hidx_c;

   // Distance of entry e from the queue head (age order, modulo N).
   function automatic logic [IDXW-1:0] age_of(input logic [IDXW-1:0] e,
                                              input logic [IDXW-1:0] base);
      return e - base;
   endfunction

   // Allocation: slot i takes tail plus the number of lower requesting slots.
   always_comb begin
      need_c = '0;
      idx_c  = '0;
      for (int i = 0; i < IW; i++) begin
         idx_c[i] = tail_q + IDXW'(need_c);
         need_c   = need_c + CNTW'(bus.alloc_req[i]);
      end
      is_idle_c = (state_q == S_IDLE);
      gnt_c = is_idle_c & ~bus.mispredict_val & (need_c != '0) &
              ((CNTW'(N) - count_q) >= need_c);
   end

   // Next-state: allocation write, in-order retire free, mispredict CAM/flush.
   always_comb begin
      state_d       = state_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      valid_d       = valid_q;
      robid_d       = robid_q;
      restore_en_d  = 1'b0;
      restore_idx_d = restore_idx_q;
      ckpt_err_d    = ckpt_err_q;
      hp_c          = head_q;
      freed_c       = '0;
      hit_c         = 1'b0;
      hidx_c        = '0;

      if (gnt_c) begin
         for (int i = 0; i < IW; i++) begin
            if (bus.alloc_req[i]) begin
               valid_d[idx_c[i]] = 1'b1;
               robid_d[idx_c[i]] = bus.alloc_robid[i];
            end
         end
         tail_d = tail_q + IDXW'(need_c);
      end

      // A retire that does not match the head entry is flagged and skipped.
      for (int k = 0; k < RW; k++) begin
         if (bus.ret_branch_val[k]) begin
            if (valid_q[hp_c] && (robid_q[hp_c] == bus.ret_robid[k])) begin
               valid_d[hp_c] = 1'b0;
               hp_c          = hp_c + IDXW'(1);
               freed_c       = freed_c + CNTW'(1);
            end else begin
               ckpt_err_d = 1'b1;
            end
         end
      end
      head_d  = hp_c;
      count_d = count_q + (gnt_c ? need_c : '0) - freed_c;

      for (int e = N - 1; e >= 0; e--) begin
         if (valid_q[e] && (robid_q[e] == bus.mispredict_robid)) begin
            hit_c  = 1'b1;
            hidx_c = IDXW'(e);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (bus.mispredict_val) begin
               if (hit_c) begin
                  state_d       = S_RESTORE;
                  restore_en_d  = 1'b1;
                  restore_idx_d = hidx_c;
                  tail_d        = hidx_c;
                  count_d       = CNTW'(age_of(hidx_c, head_d));
                  // Flush the mispredicted entry and everything younger.
                  for (int e = 0; e < N; e++) begin
                     if (age_of(IDXW'(e), head_q) >= age_of(hidx_c, head_q))
                        valid_d[e] = 1'b0;
                  end
               end else begin
                  ckpt_err_d = 1'b1;
               end
            end
         end
         S_RESTORE: state_d = S_RESUME;
         S_RESUME:  state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         valid_q       <= '0;
         robid_q       <= '0;
         restore_en_q  <= 1'b0;
         restore_idx_q <= '0;
         ckpt_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         valid_q       <= valid_d;
         robid_q       <= robid_d;
         restore_en_q  <= restore_en_d;
         restore_idx_q <= restore_idx_d;
         ckpt_err_q    <= ckpt_err_d;
      end
   end

   assign bus.alloc_gnt      = gnt_c;
   assign bus.alloc_idx      = idx_c;
   assign bus.rename_stall   = ~is_idle_c | ((need_c != '0) & ~gnt_c);
   assign bus.mispredict_rdy = is_idle_c;
   assign bus.restore_en     = restore_en_q;
   assign bus.restore_idx    = restore_idx_q;
   assign bus.bratcr_full    = (count_q == CNTW'(N));
   assign bus.ckpt_err       = ckpt_err_q;
endmodule

// File: doc/brat_ckpt_ctrl.md
# brat_ckpt_ctrl

Allocation and recovery controller for the branch RAT copy registers (BRATCR) next to the front-end RAT. It manages the checkpoint entries as a circular queue: up to two entries allocated per cycle at rename, in-order freeing as branches retire, and a CAM lookup on mispredict. A mispredict starts a restore sequence that tells the FRAT which entry to copy back and stalls rename until the copy is done.

## Interface
- ISSUE_WIDTH_MAX, 2, rename slots per cycle
- ROB_MAX_RETIRE, 2, retire slots per cycle
- ROB_SIZE_CLOG, 6, ROB id width
- BRATCR_NUM_ETY, 8, checkpoint entries (power of two)
- BRATCR_NUM_ETY_CLOG, 3, entry index width
- clk  in  1  clock; all flops on posedge
- rst_n  in  1  reset, asynchronous, active-low
- alloc_req  in  ISSUE_WIDTH_MAX  slot i holds a branch needing a checkpoint
- alloc_robid  in  ISSUE_WIDTH_MAX x ROB_SIZE_CLOG  ROB id of the branch in slot i
- alloc_gnt  out  1  checkpoints granted this cycle (comb)
- alloc_idx  out  ISSUE_WIDTH_MAX x BRATCR_NUM_ETY_CLOG  entry assigned to slot i (comb)
- rename_stall  out  1  rename must hold this cycle (comb)
- ret_branch_val  in  ROB_MAX_RETIRE  retiring correctly-predicted branch, slot k
- ret_robid  in  ROB_MAX_RETIRE x ROB_SIZE_CLOG  ROB id of the retiring branch
- mispredict_val  in  1  branch resolved mispredicted
- mispredict_robid  in  ROB_SIZE_CLOG  ROB id of the mispredicted branch
- mispredict_rdy  out  1  high only in IDLE
- restore_en  out  1  FRAT copies the checkpoint back this cycle (registered)
- restore_idx  out  BRATCR_NUM_ETY_CLOG  entry to restore (registered)
- bratcr_full  out  1  occupancy == BRATCR_NUM_ETY
- ckpt_err  out  1  sticky error flag

## Operation
- State: head, tail (BRATCR_NUM_ETY_CLOG bits, wrap modulo N); count (BRATCR_NUM_ETY_CLOG+1 bits); per-entry valid and robid; FSM IDLE/RESTORE/RESUME.
- Allocation:
  - need = popcount(alloc_req).
  - alloc_gnt = IDLE & ~mispredict_val & (need != 0) & (N - count >= need). Grants are all-or-nothing.
  - The first requesting slot gets tail and the second gets tail+1 (wrapped).
  - On grant: write robid, set valid, tail += need.
- rename_stall = ~IDLE | (need != 0 & ~alloc_gnt).
- Retire free:
  - Each ret_branch_val[k], taken in slot order, frees head and increments head.
  - ret_robid must equal the stored robid of that entry, and the entry must be valid. Otherwise set ckpt_err and skip the free.
- Mispredict, accepted when IDLE & mispredict_val:
  - CAM all valid entries for mispredict_robid.
  - Hit at index h: latch h and go to RESTORE.
  - Flush: clear valid on h and on every entry from h up to tail-1; set tail = h; count = (h - head_next) mod N.
  - Miss: set ckpt_err and stay in IDLE.
  - A mispredict_val arriving while not IDLE is ignored (mispredict_rdy low).
- FSM transitions: RESTORE → RESUME → IDLE unconditionally. Retire frees of older entries proceed in every state.
- count_next = count + granted - freed. Allocation and free in the same cycle are legal, including at full (a free does not enable a same-cycle grant; free space is evaluated on registered count).
- Outputs after reset: head=tail=count=0, all valid=0, IDLE, restore_en=0, restore_idx=0, ckpt_err=0, bratcr_full=0.
- Reset asserted mid-recovery returns to IDLE at once and drops restore_en.

## Timing
- Grant is combinational in the request cycle. alloc_idx is valid in that cycle; the FRAT writes the copy on the same edge.
- Mispredict accepted at edge T:
  - restore_en=1 and restore_idx=h during cycle T+1 (RESTORE).
  - Cycle T+2 is RESUME with rename_stall=1.
  - Cycle T+3 is IDLE and allocation is allowed again.
- Frees take effect at the next edge; bratcr_full and count reflect them from T+1.
- ckpt_err is set at the edge after the offending event and cleared only by reset.

## Test plan
- Reset, then alloc_req=2'b11 with robids 4 and 5 → alloc_gnt=1, alloc_idx={1,0}; next cycle count=2, tail=2.
- Fill to 7 entries, then alloc_req=2'b11 → alloc_gnt=0, rename_stall=1. With alloc_req=2'b01 → grant at idx 7, tail wraps to 0, bratcr_full=1.
- Full queue with ret_branch_val=2'b01 matching the head robid plus alloc_req=2'b01 in the same cycle → no grant. Next cycle count=7; a retry is granted at idx 0.
- Entries 0..4 hold robids 10..14; mispredict robid 12 → restore_en with restore_idx=2 exactly one cycle later, tail=2, count=2, rename_stall high for 2 cycles, then next grant gets idx 2.
- A second mispredict_val during RESTORE is ignored (mispredict_rdy=0). A ret_robid mismatch against the head robid → ckpt_err=1 next cycle and head unchanged.
- Deassert rst_n during RESTORE → outputs go to reset values immediately: restore_en=0, rename_stall=0 with no requests, count=0.
